// File: rtl/change_dispenser.sv
// change_dispenser: pays out a latched change amount through a coin hopper,
// one coin per request/ack handshake. Each coin is the largest denomination
// that fits the amount still owed and is still in stock. A per-denomination
// inventory count is kept, and shortfall and low-stock status are reported.
//
// Optional feature: define HOPPER_TIMEOUT_EN to abort a coin request that
// gets no hopper_ack within TIMEOUT cycles. The block then parks in FAULT
// until reset.
//
// Ports:
//   clk            system clock, rising edge
//   reset          asynchronous active-low reset
//   change_amount  amount to pay out, sampled on dispense_start
//   dispense_start one-cycle start pulse (honoured only in IDLE)
//   hopper_ack     hopper has ejected the requested coin
//   refill         reload all inventories to INV_MAX (honoured only in IDLE)
//   coin_req       coin request to the hopper
//   coin_sel       requested denomination: 0 = LO, 1 = MID, 2 = HI
//   busy           high in every state except IDLE
//   done           one-cycle completion pulse
//   shortfall      amount was not fully paid
//   remaining      amount still unpaid
//   low_stock      at least one inventory counter is zero
//
// state  | meaning
// IDLE   | waiting for dispense_start; refill accepted here
// SELECT | one cycle: choose the next coin, or finish
// REQ    | coin_req held until hopper_ack
// DONE   | done pulse, back to IDLE
// FAULT  | hopper timed out; held until reset (HOPPER_TIMEOUT_EN only)
`timescale 1ns/1ps
module change_dispenser #(
    parameter int COIN_HI  = 10,
    parameter int COIN_MID = 5,
    parameter int COIN_LO  = 1,
    parameter int INV_W    = 4,
    parameter int INV_MAX  = 15,
    parameter int TIMEOUT  = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] change_amount,
    input  logic       dispense_start,
    input  logic       hopper_ack,
    input  logic       refill,
    output logic       coin_req,
    output logic [1:0] coin_sel,
    output logic       busy,
    output logic       done,
    output logic       shortfall,
    output logic [4:0] remaining,
    output logic       low_stock
);

    typedef enum logic [2:0] {
        IDLE, SELECT, REQ, DONE
`ifdef HOPPER_TIMEOUT_EN
        , FAULT
`endif
    } state_t;

    localparam logic [1:0]       SEL_LO  = 2'd0;
    localparam logic [1:0]       SEL_MID = 2'd1;
    localparam logic [1:0]       SEL_HI  = 2'd2;
    localparam logic [4:0]       VAL_HI  = 5'(COIN_HI);
    localparam logic [4:0]       VAL_MID = 5'(COIN_MID);
    localparam logic [4:0]       VAL_LO  = 5'(COIN_LO);
    localparam logic [INV_W-1:0] INV_FULL = INV_W'(INV_MAX);
    localparam logic [INV_W-1:0] INV_ONE  = INV_W'(1);

    state_t           state, state_nx;
    logic             coin_req_nx, done_nx, shortfall_nx;
    logic [1:0]       coin_sel_nx;
    logic [4:0]       remaining_nx, sel_value;
    logic [INV_W-1:0] inv_hi, inv_mid, inv_lo;
    logic [INV_W-1:0] inv_hi_nx, inv_mid_nx, inv_lo_nx;

`ifdef HOPPER_TIMEOUT_EN
    // Down-counter loaded on entry to REQ; terminal count 0 means the
    // request has been outstanding for TIMEOUT cycles.
    localparam int            TMR_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(TIMEOUT - 1);
    localparam logic [TMR_W-1:0] TMR_ONE  = TMR_W'(1);
    logic [TMR_W-1:0] timer, timer_nx;
`endif

    always_comb begin
        sel_value = VAL_LO;
        case (coin_sel)
            SEL_HI:  sel_value = VAL_HI;
            SEL_MID: sel_value = VAL_MID;
            default: sel_value = VAL_LO;
        endcase
    end

    always_comb begin
        state_nx     = state;
        coin_req_nx  = coin_req;
        coin_sel_nx  = coin_sel;
        done_nx      = 1'b0;
        shortfall_nx = shortfall;
        remaining_nx = remaining;
        inv_hi_nx    = inv_hi;
        inv_mid_nx   = inv_mid;
        inv_lo_nx    = inv_lo;
`ifdef HOPPER_TIMEOUT_EN
        timer_nx     = timer;
`endif
        case (state)
            IDLE: begin
                // Start wins over a simultaneous refill.
                if (dispense_start) begin
                    remaining_nx = change_amount;
                    shortfall_nx = 1'b0;
                    state_nx     = SELECT;
                end else if (refill) begin
                    inv_hi_nx  = INV_FULL;
                    inv_mid_nx = INV_FULL;
                    inv_lo_nx  = INV_FULL;
                end
            end
            SELECT: begin
`ifdef HOPPER_TIMEOUT_EN
                timer_nx = TMR_LOAD;
`endif
                if (remaining == 5'd0) begin
                    state_nx = DONE;
                    done_nx  = 1'b1;
                end else if (remaining >= VAL_HI && inv_hi != '0) begin
                    coin_sel_nx = SEL_HI;
                    coin_req_nx = 1'b1;
                    state_nx    = REQ;
                end else if (remaining >= VAL_MID && inv_mid != '0) begin
                    coin_sel_nx = SEL_MID;
                    coin_req_nx = 1'b1;
                    state_nx    = REQ;
                end else if (remaining >= VAL_LO && inv_lo != '0) begin
                    coin_sel_nx = SEL_LO;
                    coin_req_nx = 1'b1;
                    state_nx    = REQ;
                end else begin
                    shortfall_nx = 1'b1;
                    state_nx     = DONE;
                    done_nx      = 1'b1;
                end
            end
            REQ: begin
                if (hopper_ack) begin
                    // Selection guaranteed sel_value <= remaining and stock > 0.
                    remaining_nx = remaining - sel_value;
                    case (coin_sel)
                        SEL_HI:  if (inv_hi  != '0) inv_hi_nx  = inv_hi  - INV_ONE;
                        SEL_MID: if (inv_mid != '0) inv_mid_nx = inv_mid - INV_ONE;
                        SEL_LO:  if (inv_lo  != '0) inv_lo_nx  = inv_lo  - INV_ONE;
                        default: ;
                    endcase
                    coin_req_nx = 1'b0;
                    state_nx    = SELECT;
                end
`ifdef HOPPER_TIMEOUT_EN
                else if (timer == '0) begin
                    coin_req_nx  = 1'b0;
                    shortfall_nx = 1'b1;
                    state_nx     = FAULT;
                end else begin
                    timer_nx = timer - TMR_ONE;
                end
`endif
            end
            DONE: state_nx = IDLE;
`ifdef HOPPER_TIMEOUT_EN
            FAULT: state_nx = FAULT;
`endif
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            coin_req  <= 1'b0;
            coin_sel  <= SEL_LO;
            busy      <= 1'b0;
            done      <= 1'b0;
            shortfall <= 1'b0;
            remaining <= 5'd0;
            inv_hi    <= INV_FULL;
            inv_mid   <= INV_FULL;
            inv_lo    <= INV_FULL;
            low_stock <= 1'b0;
`ifdef HOPPER_TIMEOUT_EN
            timer     <= TMR_LOAD;
`endif
        end else begin
            state     <= state_nx;
            coin_req  <= coin_req_nx;
            coin_sel  <= coin_sel_nx;
            busy      <= (state_nx != IDLE);
            done      <= done_nx;
            shortfall <= shortfall_nx;
            remaining <= remaining_nx;
            inv_hi    <= inv_hi_nx;
            inv_mid   <= inv_mid_nx;
            inv_lo    <= inv_lo_nx;
            // Looks at the current counters, so it trails a change by a cycle.
            low_stock <= (inv_hi == '0) || (inv_mid == '0) || (inv_lo == '0);
`ifdef HOPPER_TIMEOUT_EN
            timer     <= timer_nx;
`endif
        end
    end

endmodule

// File: tb/tb_change_dispenser.sv
// Self-checking bench for change_dispenser. A greedy payout model with its
// own inventory pushes the expected coin sequence into a queue at start; the
// hopper model pops and compares on each coin_req.
`timescale 1ns/1ps
module tb_change_dispenser;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [4:0] change_amount = 5'd0;
    logic       dispense_start = 1'b0;
    logic       hopper_ack = 1'b0;
    logic       refill = 1'b0;
    logic       coin_req;
    logic [1:0] coin_sel;
    logic       busy;
    logic       done;
    logic       shortfall;
    logic [4:0] remaining;
    logic       low_stock;

    int checks = 0;
    int errors = 0;
    int m_inv[3];
    int exp_q[$];

    always #5 clk = ~clk;

    change_dispenser dut (
        .clk(clk), .reset(reset), .change_amount(change_amount),
        .dispense_start(dispense_start), .hopper_ack(hopper_ack), .refill(refill),
        .coin_req(coin_req), .coin_sel(coin_sel), .busy(busy), .done(done),
        .shortfall(shortfall), .remaining(remaining), .low_stock(low_stock)
    );

    function automatic void model_fill();
        for (int i = 0; i < 3; i++) m_inv[i] = 15;
    endfunction

    function automatic bit model_low();
        return (m_inv[0] == 0) || (m_inv[1] == 0) || (m_inv[2] == 0);
    endfunction

    // Greedy reference: index 0 = LO(1), 1 = MID(5), 2 = HI(10).
    function automatic void model_txn(input int amt, output int rem, output bit sh);
        int val[3];
        int pick;
        val[0] = 1; val[1] = 5; val[2] = 10;
        rem = amt;
        sh  = 1'b0;
        while (rem != 0) begin
            pick = -1;
            for (int d = 2; d >= 0; d--)
                if (pick < 0 && val[d] <= rem && m_inv[d] > 0) pick = d;
            if (pick < 0) begin
                sh = 1'b1;
                break;
            end
            exp_q.push_back(pick);
            rem = rem - val[pick];
            m_inv[pick] = m_inv[pick] - 1;
        end
    endfunction

    // One full transaction with a 1-cycle-ack hopper. With poke set, a start
    // and a refill are driven during the first coin's REQ and must be ignored.
    task automatic run_txn(input string name, input int amt, input bit poke, input bit with_refill);
        int  exp_rem;
        bit  exp_sh;
        int  ndone;
        int  coins;
        int  cyc;
        int  e;
        model_txn(amt, exp_rem, exp_sh);
        @(negedge clk);
        change_amount  = 5'(amt);
        dispense_start = 1'b1;
        refill         = with_refill;
        @(negedge clk);
        dispense_start = 1'b0;
        refill         = 1'b0;
        ndone = 0; coins = 0; cyc = 0;
        while (cyc < 300) begin
            if (done) ndone++;
            if (coin_req && !hopper_ack) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL %s extra coin: coin_sel got %0d, none expected", name, coin_sel);
                end else begin
                    e = exp_q.pop_front();
                    if (coin_sel !== 2'(e)) begin
                        errors++;
                        $display("FAIL %s coin %0d: coin_sel got %0d expected %0d", name, coins, coin_sel, e);
                    end
                end
                hopper_ack = 1'b1;
                if (poke && coins == 0) begin
                    dispense_start = 1'b1;
                    refill         = 1'b1;
                    change_amount  = 5'd31;
                end
                coins++;
            end else begin
                hopper_ack     = 1'b0;
                dispense_start = 1'b0;
                refill         = 1'b0;
            end
            if (ndone > 0 && !busy) break;
            @(negedge clk);
            cyc++;
        end
        hopper_ack = 1'b0;
        checks++;
        if (cyc >= 300) begin
            errors++;
            $display("FAIL %s timeout: busy got %0b after %0d cycles, required idle", name, busy, cyc);
        end
        checks++;
        if (ndone != 1) begin
            errors++;
            $display("FAIL %s done pulses: got %0d expected 1", name, ndone);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s coins missing: %0d expected coins not paid", name, exp_q.size());
            exp_q.delete();
        end
        checks++;
        if (remaining !== 5'(exp_rem)) begin
            errors++;
            $display("FAIL %s remaining: got %0d expected %0d", name, remaining, exp_rem);
        end
        checks++;
        if (shortfall !== exp_sh) begin
            errors++;
            $display("FAIL %s shortfall: got %0b expected %0b", name, shortfall, exp_sh);
        end
        checks++;
        if (low_stock !== model_low()) begin
            errors++;
            $display("FAIL %s low_stock: got %0b expected %0b", name, low_stock, model_low());
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        model_fill();
        repeat (2) @(negedge clk);
        checks++;
        if ({coin_req, busy, done, shortfall, remaining, low_stock, coin_sel} !== 11'd0) begin
            errors++;
            $display("FAIL reset outputs: req=%0b busy=%0b done=%0b short=%0b rem=%0d low=%0b sel=%0d, required all 0",
                     coin_req, busy, done, shortfall, remaining, low_stock, coin_sel);
        end
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || low_stock !== 1'b0) begin
            errors++;
            $display("FAIL post-reset idle: busy=%0b low=%0b required 0 0", busy, low_stock);
        end
    endtask

    task automatic test_basic();
        run_txn("basic17", 17, 1'b0, 1'b0);
    endtask

    task automatic test_zero();
        int req_seen;
        req_seen = 0;
        @(negedge clk);
        change_amount  = 5'd0;
        dispense_start = 1'b1;
        @(negedge clk);
        dispense_start = 1'b0;
        if (coin_req) req_seen++;
        checks++;
        if (done !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL zero cycle1: done=%0b busy=%0b required 0 1", done, busy);
        end
        @(negedge clk);
        if (coin_req) req_seen++;
        checks++;
        if (done !== 1'b1 || shortfall !== 1'b0 || remaining !== 5'd0) begin
            errors++;
            $display("FAIL zero cycle2: done=%0b short=%0b rem=%0d required 1 0 0", done, shortfall, remaining);
        end
        @(negedge clk);
        if (coin_req) req_seen++;
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || req_seen != 0) begin
            errors++;
            $display("FAIL zero after: done=%0b busy=%0b reqs=%0d required 0 0 0", done, busy, req_seen);
        end
    endtask

    task automatic test_mid_exhaust();
        while (m_inv[1] > 0) run_txn("drain_mid", 5, 1'b0, 1'b0);
        run_txn("lo_only7", 7, 1'b0, 1'b0);
    endtask

    task automatic test_shortfall();
        while (m_inv[2] > 0) run_txn("drain_hi", 10, 1'b0, 1'b0);
        while (m_inv[0] > 2) run_txn("drain_lo", 1, 1'b0, 1'b0);
        run_txn("short4", 4, 1'b1, 1'b0);
    endtask

    task automatic test_start_refill_same();
        run_txn("start_refill", 3, 1'b0, 1'b1);
    endtask

    task automatic test_refill();
        @(negedge clk);
        refill = 1'b1;
        @(negedge clk);
        refill = 1'b0;
        model_fill();
        @(negedge clk);
        checks++;
        if (low_stock !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL refill: low_stock=%0b busy=%0b required 0 0", low_stock, busy);
        end
        run_txn("after_refill31", 31, 1'b0, 1'b0);
    endtask

    task automatic test_reset_mid();
        int cyc;
        @(negedge clk);
        change_amount  = 5'd17;
        dispense_start = 1'b1;
        @(negedge clk);
        dispense_start = 1'b0;
        cyc = 0;
        while (!coin_req && cyc < 10) begin
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (!coin_req) begin
            errors++;
            $display("FAIL reset_mid: coin_req got 0 after %0d cycles, required 1", cyc);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (coin_req !== 1'b0 || busy !== 1'b0 || remaining !== 5'd0) begin
            errors++;
            $display("FAIL reset_mid abort: req=%0b busy=%0b rem=%0d required 0 0 0", coin_req, busy, remaining);
        end
        @(negedge clk);
        reset = 1'b1;
        exp_q.delete();
        model_fill();
        @(negedge clk);
        run_txn("post_reset17", 17, 1'b0, 1'b0);
        run_txn("post_reset26", 26, 1'b0, 1'b0);
    endtask

`ifdef HOPPER_TIMEOUT_EN
    task automatic test_timeout();
        int cyc;
        int high;
        int ndone;
        @(negedge clk);
        change_amount  = 5'd5;
        dispense_start = 1'b1;
        @(negedge clk);
        dispense_start = 1'b0;
        cyc = 0; high = 0; ndone = 0;
        while (!coin_req && cyc < 10) begin
            @(negedge clk);
            cyc++;
        end
        while (coin_req && high < 40) begin
            high++;
            if (done) ndone++;
            @(negedge clk);
        end
        checks++;
        if (high != 16) begin
            errors++;
            $display("FAIL timeout req length: got %0d cycles expected 16", high);
        end
        repeat (20) begin
            if (done) ndone++;
            @(negedge clk);
        end
        checks++;
        if (shortfall !== 1'b1 || busy !== 1'b1 || remaining !== 5'd5 || coin_req !== 1'b0 || ndone != 0) begin
            errors++;
            $display("FAIL timeout fault: short=%0b busy=%0b rem=%0d req=%0b dones=%0d required 1 1 5 0 0",
                     shortfall, busy, remaining, coin_req, ndone);
        end
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        model_fill();
        @(negedge clk);
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_zero();
        test_mid_exhaust();
        test_shortfall();
        test_start_refill_same();
        test_refill();
        test_reset_mid();
`ifdef HOPPER_TIMEOUT_EN
        test_timeout();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
